// File: rtl/renode_ahb_subordinate_memory_pkg.sv
// rtl/renode_ahb_subordinate_memory_pkg.sv - AHB-Lite bus types, data-phase states and byte-mask helper
// Shared by the interface, the responder top and its backing memory.
package renode_ahb_subordinate_memory_pkg;

  typedef enum logic [1:0] {
    Idle          = 2'b00,
    Busy          = 2'b01,
    NonSequential = 2'b10,
    Sequential    = 2'b11
  } transfer_type_e;

  typedef enum logic {
    Okay  = 1'b0,
    Error = 1'b1
  } response_e;

  typedef enum logic {
    Read  = 1'b0,
    Write = 1'b1
  } transfer_direction_e;

  typedef enum logic [2:0] {
    Byte8bit          = 3'd0,
    Halfword16bit     = 3'd1,
    Word32bit         = 3'd2,
    Doubleword64bit   = 3'd3,
    Line4Word128bit   = 3'd4,
    Line8Word256bit   = 3'd5,
    Line16Word512bit  = 3'd6,
    Line32Word1024bit = 3'd7
  } transfer_size_e;

  typedef enum logic [2:0] {
    Single = 3'd0,
    Incr   = 3'd1,
    Wrap4  = 3'd2,
    Incr4  = 3'd3,
    Wrap8  = 3'd4,
    Incr8  = 3'd5,
    Wrap16 = 3'd6,
    Incr16 = 3'd7
  } burst_e;

  typedef enum logic [2:0] {
    DataIdle = 3'd0,
    DataWait = 3'd1,
    DataDone = 3'd2,
    Error1   = 3'd3,
    Error2   = 3'd4
  } data_phase_state_e;

  localparam int unsigned MaxWordAddrWidth = 32;
  localparam int unsigned MaxStrbWidth     = 8;

  // Sized for the widest supported bus; narrower instances ignore the upper bits.
  typedef struct packed {
    logic [MaxWordAddrWidth-1:0] word_addr;
    transfer_direction_e         direction;
    logic [MaxStrbWidth-1:0]     byte_mask;
    logic                        error;
  } addr_phase_t;

  function automatic logic [MaxStrbWidth-1:0] byte_mask_for(transfer_size_e size,
                                                            logic [2:0]     offset);
    logic [MaxStrbWidth-1:0] mask;
    case (size)
      Byte8bit:        mask = 8'b0000_0001 << offset;
      Halfword16bit:   mask = 8'b0000_0011 << {offset[2:1], 1'b0};
      Word32bit:       mask = 8'b0000_1111 << {offset[2], 2'b00};
      Doubleword64bit: mask = 8'b1111_1111;
      default:         mask = 8'b0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/renode_ahb_subordinate_memory_if.sv
// rtl/renode_ahb_subordinate_memory_if.sv - AHB-Lite signal bundle between manager and responder
interface renode_ahb_subordinate_memory_if
  import renode_ahb_subordinate_memory_pkg::*;
#(
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned DataWidth    = 32
);
  logic                    hsel;
  logic [AddressWidth-1:0] haddr;
  transfer_type_e          htrans;
  transfer_direction_e     hwrite;
  transfer_size_e          hsize;
  burst_e                  hburst;
  logic [DataWidth-1:0]    hwdata;
  logic                    hready;
  logic                    hreadyout;
  response_e               hresp;
  logic [DataWidth-1:0]    hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/renode_ahb_byte_enable_memory.sv
// rtl/renode_ahb_byte_enable_memory.sv - word array with per-byte write enables and combinational read
// Contents are deliberately not reset.
module renode_ahb_byte_enable_memory #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MemSizeBytes = 4096,
  parameter int unsigned AddrWidth    = 10
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic [DataWidth-1:0]   rdata_o
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned Words     = MemSizeBytes / StrbWidth;

  logic [DataWidth-1:0] mem_q [Words];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/renode_ahb_subordinate_memory.sv
// rtl/renode_ahb_subordinate_memory.sv - AHB-Lite responder backed by a byte-enable memory
// Decodes address phases, inserts wait states, and returns the two-cycle ERROR response.
module renode_ahb_subordinate_memory
  import renode_ahb_subordinate_memory_pkg::*;
#(
  parameter int unsigned     AddressWidth = 32,
  parameter int unsigned     DataWidth    = 32,
  parameter longint unsigned BaseAddress  = 0,
  parameter int unsigned     MemSizeBytes = 4096,
  parameter int unsigned     WaitStates   = 0
) (
  input logic hclk,
  input logic hreset,
  renode_ahb_subordinate_memory_if.slave bus
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned StrbLog   = $clog2(StrbWidth);
  localparam int unsigned Words     = MemSizeBytes / StrbWidth;
  localparam int unsigned WordAw    = (Words > 1) ? $clog2(Words) : 1;

  data_phase_state_e state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  addr_phase_t       phase_q, phase_d;
  addr_phase_t       new_phase;

  logic [63:0]          addr_ext;
  logic [63:0]          addr_off;
  logic [2:0]           addr_low;
  logic [2:0]           lane_off;
  logic                 out_of_range;
  logic                 misaligned;
  logic                 too_big;
  logic                 can_accept;
  logic                 accept;
  logic                 mem_we;
  logic [StrbWidth-1:0] strb;
  logic [DataWidth-1:0] lane_mask;
  logic [DataWidth-1:0] mem_rdata;
  logic                 ready_out;
  response_e            resp_out;
  logic [DataWidth-1:0] rdata_out;
  logic                 unused_bits;

  // Address decode is done in 64 bits so BaseAddress+MemSizeBytes cannot wrap.
  assign addr_ext     = 64'(bus.haddr);
  assign addr_off     = addr_ext - BaseAddress;
  assign addr_low     = bus.haddr[2:0];
  assign lane_off     = addr_low & 3'(StrbWidth - 1);
  assign out_of_range = (addr_ext < BaseAddress) ||
                        (addr_ext >= BaseAddress + 64'(MemSizeBytes));
  assign too_big      = 32'(bus.hsize) > StrbLog;

  always_comb begin
    misaligned = 1'b0;
    case (bus.hsize)
      Byte8bit:      misaligned = 1'b0;
      Halfword16bit: misaligned = addr_low[0];
      Word32bit:     misaligned = |addr_low[1:0];
      default:       misaligned = |addr_low;
    endcase
  end

  always_comb begin
    new_phase           = '0;
    new_phase.word_addr = MaxWordAddrWidth'(addr_off >> StrbLog);
    new_phase.direction = bus.hwrite;
    new_phase.byte_mask = byte_mask_for(bus.hsize, lane_off);
    new_phase.error     = out_of_range | misaligned | too_big;
  end

  // Only states that present hreadyout=1 can be ending a data phase on this edge.
  assign can_accept = (state_q == DataIdle) || (state_q == DataDone) || (state_q == Error2);
  assign accept     = can_accept && bus.hsel && bus.hready &&
                      ((bus.htrans == NonSequential) || (bus.htrans == Sequential));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    case (state_q)
      DataWait: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q + 4'd1 == 4'(WaitStates)) begin
          state_d = DataDone;
        end
      end
      Error1: state_d = Error2;
      default: begin
        state_d = DataIdle;
        if (accept) begin
          phase_d = new_phase;
          cnt_d   = 4'd0;
          if (new_phase.error) begin
            state_d = Error1;
          end else if (WaitStates == 0) begin
            state_d = DataDone;
          end else begin
            state_d = DataWait;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= DataIdle;
      cnt_q   <= 4'd0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    ready_out = 1'b1;
    resp_out  = Okay;
    case (state_q)
      DataWait: ready_out = 1'b0;
      Error1: begin
        ready_out = 1'b0;
        resp_out  = Error;
      end
      Error2:  resp_out = Error;
      default: ;
    endcase
  end

  assign strb = phase_q.byte_mask[StrbWidth-1:0];

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < StrbWidth; b++) begin
      lane_mask[b*8 +: 8] = {8{strb[b]}};
    end
  end

  // Gating with hreset keeps a write in its final cycle from landing during reset.
  assign mem_we    = (state_q == DataDone) && (phase_q.direction == Write) && !hreset;
  assign rdata_out = ((state_q == DataDone) && (phase_q.direction == Read)) ?
                     (mem_rdata & lane_mask) : '0;

  renode_ahb_byte_enable_memory #(
    .DataWidth    (DataWidth),
    .MemSizeBytes (MemSizeBytes),
    .AddrWidth    (WordAw)
  ) u_mem (
    .clk_i   (hclk),
    .we_i    (mem_we),
    .addr_i  (phase_q.word_addr[WordAw-1:0]),
    .be_i    (strb),
    .wdata_i (bus.hwdata),
    .rdata_o (mem_rdata)
  );

  assign bus.hreadyout = ready_out;
  assign bus.hresp     = resp_out;
  assign bus.hrdata    = rdata_out;

  assign unused_bits = ^{bus.hburst, phase_q.word_addr >> WordAw,
                         phase_q.byte_mask >> StrbWidth};

endmodule
